// File: rtl/bus_arbiter_if.sv
// Bundle of the CPU, DMA and memory-bus signals of the two-requester arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_re;
  logic        mem_we;

  logic        owner;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  owner, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving a CPU and a DMA requester access to a single
// memory bus. One access at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles)
// -> ACK (one-cycle completion strobe to the grantee) -> IDLE.
module bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic          clock,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  state_t      state_nx;
  logic        owner_q;
  logic        last_owner;
  logic        we_q;
  logic [2:0]  wait_cnt;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  cpu_rdata_q;
  logic [7:0]  dma_rdata_q;
  logic        any_req;
  logic        grant_dma;

  // Grant decision: a lone requester wins; on a tie the one that was not served last wins.
  always_comb begin
    any_req   = bus.cpu_req | bus.dma_req;
    grant_dma = bus.dma_req & (~bus.cpu_req | ~last_owner);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and bus/handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.dma_ack   = 1'b0;
    bus.busy      = (state != IDLE);
    bus.owner     = owner_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dma_rdata = dma_rdata_q;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        bus.mem_re = ~we_q;
        bus.mem_we = we_q & (wait_cnt == 3'd0);
        if (wait_cnt == 3'd0) state_nx = ACK;
      end
      ACK: begin
        bus.cpu_ack = ~owner_q;
        bus.dma_ack = owner_q;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latch on grant, wait-state countdown, read capture and round-robin history.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= 1'b0;
      last_owner  <= 1'b1;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_q  <= grant_dma;
            we_q     <= grant_dma ? bus.dma_we    : bus.cpu_we;
            addr_q   <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
            wdata_q  <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
            wait_cnt <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else if (!we_q) begin
            if (owner_q) dma_rdata_q <= bus.mem_rdata;
            else         cpu_rdata_q <= bus.mem_rdata;
          end
        end
        ACK: begin
          last_owner <= owner_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: WAIT_STATES, default 1, extra memory cycles per access (legal 0..7).
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU access type: 1=write, 0=read.
REQ-006 cpu_addr  input  16  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  CPU read data.
REQ-009 cpu_ack  output  1  one-cycle CPU completion strobe.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same directions, widths and meanings as the cpu_* ports, for the DMA requester.
REQ-011 mem_addr  output  16  memory bus address.
REQ-012 mem_wdata  output  8  memory bus write data.
REQ-013 mem_re  output  1  memory read enable.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_rdata  input  8  memory read data, valid while mem_re is high.
REQ-016 owner  output  1  current grantee: 0=CPU, 1=DMA.
REQ-017 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states, IDLE, ACCESS and ACK, with transitions IDLE->ACCESS on any request, ACCESS->ACK when wait_cnt==0, and ACK->IDLE unconditionally.
REQ-019 In IDLE, requests SHALL be sampled each cycle; with one request high, that requester is granted.
REQ-020 With both requests high in IDLE, the requester that is not last_owner SHALL be granted (round-robin).
REQ-021 On grant, the arbiter SHALL latch owner, we, addr and wdata from the grantee and load wait_cnt=WAIT_STATES (3 bits).
REQ-022 Requester input changes after grant SHALL be ignored until the next IDLE.
REQ-023 In ACCESS, mem_addr SHALL equal the latched address.
REQ-024 In ACCESS, mem_wdata SHALL equal the latched data.
REQ-025 For reads, mem_re SHALL be high throughout ACCESS.
REQ-026 For writes, mem_we SHALL be high only in the final ACCESS cycle (wait_cnt==0): exactly one write strobe per access.
REQ-027 In ACCESS with wait_cnt!=0, wait_cnt SHALL decrement.
REQ-028 In ACCESS with wait_cnt==0, a read SHALL capture mem_rdata into the grantee's rdata register.
REQ-029 In ACK, the grantee's ack SHALL be high for exactly one cycle, and last_owner SHALL be updated to the grantee.
REQ-030 cpu_ack and dma_ack SHALL never be high in the same cycle.
REQ-031 Each rdata output SHALL hold its value until that requester's next completed read; writes SHALL NOT alter rdata.
REQ-032 Latency: request sampled in IDLE cycle N -> ACCESS cycles N+1..N+1+WAIT_STATES -> ack in cycle N+2+WAIT_STATES.
REQ-033 A requester SHALL drop req on the edge ending its ack cycle; a req still high in the following IDLE is a new request.
REQ-034 In IDLE and ACK, mem_re and mem_we SHALL be 0, while mem_addr and mem_wdata hold their last latched values.
REQ-035 busy SHALL be 0 only in IDLE.
REQ-036 owner SHALL reflect the latched grantee.
REQ-037 No request in IDLE SHALL leave all state unchanged.

Reset
REQ-038 While reset is high at a rising edge, the block SHALL enter IDLE and clear owner, last_owner (set to 1, so the CPU wins the first tie), wait_cnt, mem_addr, mem_wdata, cpu_rdata and dma_rdata; mem_re, mem_we, cpu_ack, dma_ack and busy SHALL be 0 from that edge.
REQ-039 Reset during ACCESS or ACK SHALL abandon the transaction: no ack, no write strobe after the reset edge.
REQ-040 Requests SHALL be ignored in any cycle in which reset is high.

Verification
REQ-041 WAIT_STATES=1; CPU read 0x1234 with mem_rdata=0xA5 -> mem_re high 2 cycles, cpu_ack 3 cycles after grant sample, cpu_rdata=0xA5.
REQ-042 WAIT_STATES=0; DMA write 0x55 to 0xFFFE -> one mem_we pulse with addr 0xFFFE and data 0x55, dma_ack next cycle, dma_rdata unchanged.
REQ-043 Both requesters assert together after reset -> CPU served first, then DMA; repeated continuous requests alternate CPU, DMA, CPU, DMA.
REQ-044 Change cpu_addr from 0x0100 to 0x0200 mid-ACCESS -> mem_addr stays 0x0100 to completion.
REQ-045 Assert reset during the write ACCESS with WAIT_STATES=3 -> no mem_we, no ack, busy=0 and all outputs at reset values on the next cycle.
REQ-046 WAIT_STATES=7 read -> mem_re high exactly 8 cycles, single ack.
